// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute stage to a word-wide DataMemory that has a single write enable
//   and no byte enables. Loads fetch a whole word, pick the lane and sign/zero-extend it.
//   Sub-word stores use read-modify-write. Only one request is in flight at a time.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/size/uns       store flag, size (00 byte, 01 half, 1x word), unsigned-load flag
//   req_addr/req_wdata    byte address and store data (lane taken from the LSBs)
//   rsp_valid             one-cycle completion pulse for loads and stores
//   rsp_rdata             extended load data, held until the next load completes
//   rsp_err               misaligned-access flag, qualified by rsp_valid
//   mem_we/size/addr      DataMemory controls (size fixed to word)
//   mem_wdata/mem_rdata   DataMemory write data and registered read data
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned half/word requests complete immediately with
//                     rsp_err=1 and no memory access; otherwise the low address bits are
//                     cleared and rsp_err is tied low.

module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_uns,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StLdAddr,
        StLdCap,
        StStRd,
        StStMerge,
        StStWr,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;   // only sub-word stores need the latched data
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_fmt;
    logic [DATA_WIDTH-1:0]   st_merge;
    logic [ADDR_WIDTH+1:0]   req_addr_al;

`ifdef MISALIGN_TRAP_EN
    logic                    err_q, err_d;
    logic                    misalign;

    always_comb begin
        misalign = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    end
`endif

    // Misaligned low bits are dropped; with the trap enabled such requests never reach memory.
    always_comb begin
        req_addr_al = req_addr;
        if (req_size[1]) begin
            req_addr_al[1:0] = 2'b00;
        end else if (req_size == 2'b01) begin
            req_addr_al[0] = 1'b0;
        end
    end

    // Load lane select and extension from the registered memory word.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_fmt = uns_q ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                    : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = uns_q ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                    : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // Sub-word store: overlay the new lane onto the word just read.
    always_comb begin
        st_merge = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   st_merge[7:0]   = wdata_q[7:0];
                2'b01:   st_merge[15:8]  = wdata_q[7:0];
                2'b10:   st_merge[23:16] = wdata_q[7:0];
                default: st_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            st_merge[31:16] = wdata_q;
        end else begin
            st_merge[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    addr_d  = req_addr_al;
                    wdata_d = req_wdata[15:0];
                    if (!req_we) begin
                        state_d = StLdAddr;
                    end else if (req_size[1]) begin
                        mem_wdata_d = req_wdata;
                        state_d     = StStWr;
                    end else begin
                        state_d = StStRd;
                    end
`ifdef MISALIGN_TRAP_EN
                    err_d = misalign;
                    if (misalign) begin
                        state_d = StResp;
                    end
`endif
                end
            end
            StLdAddr:  state_d = StLdCap;
            StLdCap: begin
                rsp_rdata_d = ld_fmt;
                state_d     = StResp;
            end
            StStRd:    state_d = StStMerge;
            StStMerge: begin
                mem_wdata_d = st_merge;
                state_d     = StStWr;
            end
            StStWr:    state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            mem_wdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        mem_we    = (state_q == StStWr);
        mem_size  = 2'b10;
        mem_addr  = addr_q[ADDR_WIDTH+1:2];
        mem_wdata = mem_wdata_q;
        rsp_rdata = rsp_rdata_q;
`ifdef MISALIGN_TRAP_EN
        rsp_err   = rsp_valid & err_q;
`else
        rsp_err   = 1'b0;
`endif
    end

    // we_q is latched for completeness of the captured request; the FSM path already encodes it.
    logic unused_we;
    assign unused_we = we_q;

endmodule
